// File: rtl/fazyrv_rf_chunked_if.sv
// Bit-serial register file port bundle: sweep request, per-cycle data chunks
// and the debug peek path.
interface fazyrv_rf_chunked_if #(
  parameter int CHUNKSIZE = 2
);
   logic                 start_i;
   logic [4:0]           rs1_i, rs2_i, rd_i;
   logic                 we_i;
   logic [CHUNKSIZE-1:0] res_i;
   logic [CHUNKSIZE-1:0] ra_o, rb_o;
   logic                 busy_o, done_o;
   logic [4:0]           dbg_addr_i;
   logic [31:0]          dbg_dat_o;

   modport master (
      output start_i, rs1_i, rs2_i, rd_i, we_i, res_i, dbg_addr_i,
      input  ra_o, rb_o, busy_o, done_o, dbg_dat_o
   );

   modport slave (
      input  start_i, rs1_i, rs2_i, rd_i, we_i, res_i, dbg_addr_i,
      output ra_o, rb_o, busy_o, done_o, dbg_dat_o
   );
endinterface

// File: rtl/fazyrv_rf_chunked.sv
// Chunked register file: each register is a rotate-right shift register that
// streams CHUNKSIZE bits per cycle over an N-cycle sweep.
module fazyrv_rf_chunked #(
  parameter int CHUNKSIZE  = 2,
  parameter int NREGS      = 32,
  parameter int CLR_ON_RST = 1
) (
   input logic clk_i,
   input logic rst_in,
   fazyrv_rf_chunked_if.slave bus
);
   localparam int N  = 32 / CHUNKSIZE;
   localparam int CW = $clog2(N);
   localparam int AW = (NREGS == 16) ? 4 : 5;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [AW-1:0] rs1_q, rs2_q, rd_q;
   logic          we_q;
   logic          accept;
   logic          busy, last;

   assign busy = (state == SWEEP);
   assign last = busy && (cnt == CW'(N-1));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
         IDLE: if (bus.start_i) begin
            state_nxt = SWEEP;
            cnt_nxt   = '0;
            accept    = 1'b1;
         end
         SWEEP: begin
            cnt_nxt = cnt + CW'(1);
            if (last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         state <= IDLE;
         cnt   <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         rd_q  <= '0;
         we_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            rs1_q <= bus.rs1_i[AW-1:0];
            rs2_q <= bus.rs2_i[AW-1:0];
            rd_q  <= bus.rd_i[AW-1:0];
            we_q  <= bus.we_i;
         end
      end
   end

   // Entry 0 is a constant zero, so x0 never gets a flop.
   logic [NREGS-1:0][31:0] view;
   assign view[0] = '0;

   for (genvar i = 1; i < NREGS; i++) begin : g_reg
      logic [31:0] r;
      logic        wr, sh;
      assign wr = we_q && (rd_q == AW'(i));
      // One shift per cycle no matter how many of rs1/rs2/rd hit this entry.
      assign sh = busy && (wr || rs1_q == AW'(i) || rs2_q == AW'(i));
      always_ff @(posedge clk_i) begin
         if (!rst_in) begin
            if (CLR_ON_RST != 0) r <= '0;
         end else if (sh) begin
            r <= {(wr ? bus.res_i : r[CHUNKSIZE-1:0]), r[31:CHUNKSIZE]};
         end
      end
      assign view[i] = r;
   end

   assign bus.busy_o    = busy;
   assign bus.done_o    = last;
   assign bus.ra_o      = busy ? view[rs1_q][CHUNKSIZE-1:0] : '0;
   assign bus.rb_o      = busy ? view[rs2_q][CHUNKSIZE-1:0] : '0;
   assign bus.dbg_dat_o = view[bus.dbg_addr_i[AW-1:0]];
endmodule

// File: doc/fazyrv_rf_chunked.md
FAZYRV_RF_CHUNKED -- requirements
Module: fazyrv_rf_chunked

Interface
REQ-001 Parameter CHUNKSIZE, default 2, chunk width in bits per cycle; legal values 1, 2, 4, 8.
REQ-002 Parameter NREGS, default 32, register count; legal values 16 (RV32E) and 32.
REQ-003 Parameter CLR_ON_RST, default 1; 1 = registers cleared by reset, 0 = registers keep their contents through reset.
REQ-004 clk_i  in  1  clock; rising edge only.
REQ-005 rst_in  in  1  reset; synchronous, active-low.
REQ-006 start_i  in  1  request a register-file sweep.
REQ-007 rs1_i, rs2_i, rd_i  in  5 each  source and destination addresses; sampled on start.
REQ-008 we_i  in  1  write enable for rd; sampled on start.
REQ-009 res_i  in  CHUNKSIZE  rd write-data chunk for the current sweep cycle.
REQ-010 ra_o, rb_o  out  CHUNKSIZE  current chunk of rs1 and rs2.
REQ-011 busy_o  out  1  sweep in progress.
REQ-012 done_o  out  1  one-cycle pulse in the last sweep cycle.
REQ-013 dbg_addr_i  in  5  debug peek address.
REQ-014 dbg_dat_o  out  32  full 32-bit content of register dbg_addr_i.

Function
REQ-015 Define N = 32/CHUNKSIZE.
- Internal counter cnt, width log2(N).
- Latched addresses rs1_q, rs2_q, rd_q and latched we_q.
REQ-016 Two states, IDLE and SWEEP.
- IDLE -> SWEEP when start_i=1; at that edge, latch addresses and we_i, and set cnt=0.
- SWEEP: cnt increments every cycle; SWEEP -> IDLE at the edge where cnt=N-1.
REQ-017 start_i is ignored while busy_o=1. Back-to-back sweeps are legal: start_i in the done_o cycle is not accepted; start_i in the following cycle is.
REQ-018 busy_o = (state==SWEEP).
REQ-019 done_o = busy_o && cnt==N-1.
REQ-020 In sweep cycle k (cnt=k):
- ra_o = bits [k*CHUNKSIZE +: CHUNKSIZE] of rs1's pre-sweep value; rb_o likewise for rs2.
- ra_o and rb_o are combinational from register storage.
REQ-021 Storage per register is a rotate-right-by-CHUNKSIZE shift register; the LSB chunk is the output.
REQ-022 In each SWEEP cycle, only the registers addressed by rs1_q, rs2_q and rd_q (when we_q=1) shift. Each distinct register shifts exactly once per cycle, even when addresses coincide.
REQ-023 On a shift:
- With rd_q and we_q=1: res_i enters the MSB chunk.
- Otherwise: the outgoing LSB chunk re-enters the MSB chunk.
- After N shifts every register is realigned.
REQ-024 When rd_q equals rs1_q or rs2_q and we_q=1, reads see old data: ra_o/rb_o in cycle k show the old chunk k, and the new value is visible from the next sweep.
REQ-025 Register 0 reads as zero on ra_o, rb_o and dbg_dat_o. Writes to register 0 are discarded, and no storage is inferred for it.
REQ-026 When NREGS=16, address bit 4 is ignored (index = addr[3:0]) for rs1, rs2, rd and dbg_addr.
REQ-027 ra_o = rb_o = 0 while IDLE.
REQ-028 dbg_dat_o is valid only while IDLE; its value during SWEEP is unspecified.
REQ-029 Non-addressed registers never change, under any input.

Reset
REQ-030 While rst_in=0 at a rising edge: state=IDLE, cnt=0, latched addresses=0, we_q=0.
- Outputs after reset: busy_o=0, done_o=0, ra_o=0, rb_o=0.
REQ-031 With CLR_ON_RST=1, all registers are zero after reset.
REQ-032 With CLR_ON_RST=0:
- Registers not addressed by an interrupted sweep keep their value.
- Registers addressed by an interrupted sweep have unspecified content.
REQ-033 start_i asserted in the same cycle as rst_in=0 is not accepted.

Verification
REQ-034 CHUNKSIZE=2, rd=5, we=1, res chunks forming 0xDEADBEEF (LSB chunk first) -> busy_o high 16 cycles, done_o in the 16th; afterwards dbg_addr=5 gives 0xDEADBEEF.
REQ-035 Sweep rs1=5, rs2=5, rd=5, we=1, res chunks forming 0x12345678, with x5=0xDEADBEEF -> ra_o and rb_o chunks reassemble 0xDEADBEEF; afterwards dbg gives 0x12345678.
REQ-036 Sweep rd=0, we=1, res chunks forming 0xFFFFFFFF, then sweep rs1=0 -> ra_o=0 every cycle; dbg addr 0 gives 0.
REQ-037 Sweep rs1=3, rd=7, we=0, with x3=0xA5A5A5A5 and x7=0x11111111 -> ra_o chunks form 0xA5A5A5A5; x3 and x7 unchanged afterwards; all other registers unchanged.
REQ-038 Reset asserted at cnt=4 mid-sweep, CLR_ON_RST=1 -> next cycle busy_o=0 and done_o=0; every dbg read returns 0.
REQ-039 Repeat REQ-034 for CHUNKSIZE in {1,4,8} with NREGS=16, rd=21 (aliases x5) -> sweep length 32/8/4 cycles; dbg addr 5 gives 0xDEADBEEF.
